// File: rtl/servant_mux_n.sv
// servant_mux_n: Wishbone address decoder and response multiplexer between the
// SERV CPU bus and NS peripheral slots. The top SEL_W address bits pick the
// slot. Native-ack slots may insert wait states and are guarded by a timeout.
// Legacy slots are acked automatically after one BUSY cycle. Unmapped slots
// and timeouts return an error response and update a sticky error register.
module servant_mux_n #(
  parameter int              NS         = 6,
  parameter int              SEL_W      = 3,
  parameter logic [NS-1:0]   NATIVE_ACK = 6'b110000,
  parameter int              TIMEOUT    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_wb_cpu_adr,
  input  logic [31:0]       i_wb_cpu_dat,
  input  logic [3:0]        i_wb_cpu_sel,
  input  logic              i_wb_cpu_we,
  input  logic              i_wb_cpu_cyc,
  output logic [31:0]       o_wb_cpu_rdt,
  output logic              o_wb_cpu_ack,
  input  logic              i_err_clr,
  output logic              o_err,
  output logic [31:0]       o_err_adr,
  output logic [31:0]       o_wb_s_adr,
  output logic [31:0]       o_wb_s_dat,
  output logic [3:0]        o_wb_s_sel,
  output logic              o_wb_s_we,
  output logic [NS-1:0]     o_wb_s_cyc,
  input  logic [NS*32-1:0]  i_wb_s_rdt,
  input  logic [NS-1:0]     i_wb_s_ack
);

  localparam int          NSLOT   = 2 ** SEL_W;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             err_q, err_d;
  logic [31:0]      err_adr_q, err_adr_d;
  logic             err_set;

  // Per-slot views padded out to the full decode range, so that the slot
  // index can address every position and unmapped ones read as "absent".
  logic [31:0]      slot_rdt [NSLOT];
  logic [NSLOT-1:0] slot_ack;
  logic [NSLOT-1:0] slot_native;
  logic [NSLOT-1:0] slot_mapped;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NS) begin : g_map
        assign slot_rdt[gi]    = i_wb_s_rdt[32*gi +: 32];
        assign slot_ack[gi]    = i_wb_s_ack[gi];
        assign slot_native[gi] = NATIVE_ACK[gi];
        assign slot_mapped[gi] = 1'b1;
        // Slave cyc follows the CPU cyc combinationally so an abort is seen
        // by the slave in the same cycle.
        assign o_wb_s_cyc[gi]  = (state_q == BUSY) && (slot_q == SEL_W'(gi)) && i_wb_cpu_cyc;
      end else begin : g_unmap
        assign slot_rdt[gi]    = 32'h0;
        assign slot_ack[gi]    = 1'b0;
        assign slot_native[gi] = 1'b0;
        assign slot_mapped[gi] = 1'b0;
      end
    end
  endgenerate

  assign o_wb_s_adr   = i_wb_cpu_adr;
  assign o_wb_s_dat   = i_wb_cpu_dat;
  assign o_wb_s_sel   = i_wb_cpu_sel;
  assign o_wb_s_we    = i_wb_cpu_we;
  assign o_wb_cpu_ack = (state_q == DONE);
  assign o_wb_cpu_rdt = rdt_q;
  assign o_err        = err_q;
  assign o_err_adr    = err_adr_q;

  // Next-state logic: decode, wait for ack or timeout, then one ack cycle.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    rdt_d   = rdt_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wb_cpu_cyc) begin
          slot_d  = i_wb_cpu_adr[31 -: SEL_W];
          cnt_d   = 16'h0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!i_wb_cpu_cyc) begin
          state_d = IDLE;
        end else if (!slot_mapped[slot_q]) begin
          rdt_d   = 32'h0;
          err_set = 1'b1;
          state_d = DONE;
        end else if (!slot_native[slot_q]) begin
          rdt_d   = slot_rdt[slot_q];
          state_d = DONE;
        end else if (slot_ack[slot_q]) begin
          rdt_d   = slot_rdt[slot_q];
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          rdt_d   = 32'hDEAD_BEEF;
          err_set = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky error: a new error beats a simultaneous clear, and the address is
  // recaptured whenever this error is the first one since the last clear.
  always_comb begin
    err_d     = err_q;
    err_adr_d = err_adr_q;
    if (err_set) begin
      err_d = 1'b1;
      if (!err_q || i_err_clr) begin
        err_adr_d = i_wb_cpu_adr;
      end
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      cnt_q     <= 16'h0;
      rdt_q     <= 32'h0;
      err_q     <= 1'b0;
      err_adr_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      rdt_q     <= rdt_d;
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

endmodule

// File: tb/tb_servant_mux_n.sv
// Bench for servant_mux_n: six slots, slots 4 and 5 native-ack, short timeout.
// Expected responses are queued when a request is issued and compared when
// the ack appears.
module tb_servant_mux_n;

  localparam int NS      = 6;
  localparam int TIMEOUT = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    adr, dat;
  logic [3:0]     sel;
  logic           we, cyc, err_clr;
  logic [31:0]    rdt, err_adr;
  logic           ack, err;
  logic [31:0]    s_adr, s_dat;
  logic [3:0]     s_sel;
  logic           s_we;
  logic [NS-1:0]  s_cyc;
  logic [NS*32-1:0] s_rdt;
  logic [NS-1:0]  s_ack;

  logic           s5_force;
  int             s4_cnt;

  typedef struct {
    logic [31:0] rdt;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  servant_mux_n #(
    .NS(NS), .SEL_W(3), .NATIVE_ACK(6'b110000), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel),
    .i_wb_cpu_we(we), .i_wb_cpu_cyc(cyc),
    .o_wb_cpu_rdt(rdt), .o_wb_cpu_ack(ack),
    .i_err_clr(err_clr), .o_err(err), .o_err_adr(err_adr),
    .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel),
    .o_wb_s_we(s_we), .o_wb_s_cyc(s_cyc),
    .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack)
  );

  // Slot read data, fixed for the whole run.
  assign s_rdt = {32'h5555_5555, 32'hCAFE_F00D, 32'h3333_3333,
                  32'h2222_2222, 32'h0000_0001, 32'h0000_5A5A};

  // Slot 4 acks in its 5th BUSY cycle; slot 5 may be forced to ack to show
  // that acks from non-selected slots are ignored. Auto-ack slots never ack.
  always @(posedge clk) begin
    if (s_cyc[4]) s4_cnt <= s4_cnt + 1;
    else          s4_cnt <= 0;
  end
  assign s_ack = {s5_force, (s_cyc[4] && s4_cnt == 4), 4'b0000};

  task automatic wait_ack(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", ack); end
    checks++; if (rdt !== 32'h0) begin errors++; $display("FAIL reset_rdt: got %h expected 0", rdt); end
    checks++; if (s_cyc !== 6'b0) begin errors++; $display("FAIL reset_scyc: got %b expected 000000", s_cyc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if (err_adr !== 32'h0) begin errors++; $display("FAIL reset_err_adr: got %h expected 0", err_adr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_auto_ack();
    int lat; bit got; exp_t e;
    sb.push_back('{32'h0000_0001, 1'b0, 2});
    adr = 32'h2000_0000; we = 1'b0; cyc = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_cyc !== 6'b000010) begin errors++; $display("FAIL auto_scyc: got %b expected 000010", s_cyc); end
    wait_ack(lat, got); lat++;
    e = sb.pop_front();
    checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL auto_lat: got %0d (ack=%0b) expected %0d", lat, got, e.lat); end
    checks++; if (rdt !== e.rdt) begin errors++; $display("FAIL auto_rdt: got %h expected %h", rdt, e.rdt); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL auto_err: got %0b expected %0b", err, e.err); end
    $display("txn auto read adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL auto_ack_single: got %0b expected 0", ack); end
    // Writes also return the selected slot's read data.
    sb.push_back('{32'h2222_2222, 1'b0, 2});
    adr = 32'h4000_0000; we = 1'b1; dat = 32'h1234_5678; cyc = 1'b1;
    wait_ack(lat, got);
    e = sb.pop_front();
    checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL write_lat: got %0d (ack=%0b) expected %0d", lat, got, e.lat); end
    checks++; if (rdt !== e.rdt) begin errors++; $display("FAIL write_rdt: got %h expected %h", rdt, e.rdt); end
    $display("txn auto write adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdt !== 32'h2222_2222) begin errors++; $display("FAIL rdt_hold: got %h expected 22222222", rdt); end
  endtask

  task automatic test_native_wait();
    int lat; bit got; exp_t e;
    s5_force = 1'b1;
    sb.push_back('{32'hCAFE_F00D, 1'b0, 6});
    adr = 32'h8000_0010; cyc = 1'b1;
    wait_ack(lat, got);
    e = sb.pop_front();
    checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL native_lat: got %0d (ack=%0b) expected %0d", lat, got, e.lat); end
    checks++; if (rdt !== e.rdt) begin errors++; $display("FAIL native_rdt: got %h expected %h", rdt, e.rdt); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL native_err: got %0b expected %0b", err, e.err); end
    checks++; if (s_adr !== 32'h8000_0010) begin errors++; $display("FAIL native_sadr: got %h expected 80000010", s_adr); end
    $display("txn native read adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0; s5_force = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int lat; bit got; exp_t e;
    sb.push_back('{32'hDEAD_BEEF, 1'b1, TIMEOUT + 1});
    adr = 32'hA000_0000; cyc = 1'b1;
    wait_ack(lat, got);
    e = sb.pop_front();
    checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL timeout_lat: got %0d (ack=%0b) expected %0d", lat, got, e.lat); end
    checks++; if (rdt !== e.rdt) begin errors++; $display("FAIL timeout_rdt: got %h expected %h", rdt, e.rdt); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL timeout_err: got %0b expected %0b", err, e.err); end
    checks++; if (err_adr !== 32'hA000_0000) begin errors++; $display("FAIL timeout_err_adr: got %h expected a0000000", err_adr); end
    $display("txn timeout adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unmapped();
    int lat; bit got; exp_t e;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err: got %0b expected 0", err); end
    checks++; if (err_adr !== 32'hA000_0000) begin errors++; $display("FAIL clr_err_adr: got %h expected a0000000", err_adr); end
    // First unmapped access captures its address.
    sb.push_back('{32'h0, 1'b1, 2});
    adr = 32'hC000_0004; cyc = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_cyc !== 6'b0) begin errors++; $display("FAIL unmapped_scyc: got %b expected 000000", s_cyc); end
    wait_ack(lat, got); lat++;
    e = sb.pop_front();
    checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL unmapped_lat: got %0d (ack=%0b) expected %0d", lat, got, e.lat); end
    checks++; if (rdt !== e.rdt) begin errors++; $display("FAIL unmapped_rdt: got %h expected %h", rdt, e.rdt); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL unmapped_err: got %0b expected %0b", err, e.err); end
    checks++; if (err_adr !== 32'hC000_0004) begin errors++; $display("FAIL unmapped_err_adr: got %h expected c0000004", err_adr); end
    $display("txn unmapped adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0;
    @(posedge clk); #1;
    // Second error must not overwrite the captured address.
    sb.push_back('{32'h0, 1'b1, 2});
    adr = 32'hE000_0000; cyc = 1'b1;
    wait_ack(lat, got);
    e = sb.pop_front();
    checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL second_lat: got %0d (ack=%0b) expected %0d", lat, got, e.lat); end
    checks++; if (err_adr !== 32'hC000_0004) begin errors++; $display("FAIL second_err_adr: got %h expected c0000004", err_adr); end
    $display("txn unmapped adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0;
    @(posedge clk); #1;
    // Clear in the same cycle as a new error: error wins, address recaptured.
    sb.push_back('{32'h0, 1'b1, 2});
    adr = 32'hE000_0008; cyc = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b1;
    wait_ack(lat, got); lat++;
    err_clr = 1'b0;
    e = sb.pop_front();
    checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL clr_race_lat: got %0d (ack=%0b) expected %0d", lat, got, e.lat); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL clr_race_err: got %0b expected %0b", err, e.err); end
    checks++; if (err_adr !== 32'hE000_0008) begin errors++; $display("FAIL clr_race_err_adr: got %h expected e0000008", err_adr); end
    $display("txn unmapped+clr adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort_reset();
    int lat; bit got; exp_t e; int stray;
    sb.push_back('{32'h3333_3333, 1'b0, 2});
    adr = 32'h6000_0000; cyc = 1'b1;
    wait_ack(lat, got);
    e = sb.pop_front();
    checks++; if (!got || rdt !== e.rdt) begin errors++; $display("FAIL pre_abort_rdt: got %h (ack=%0b) expected %h", rdt, got, e.rdt); end
    $display("txn auto read adr=%h rdt=%h lat=%0d", adr, rdt, lat);
    cyc = 1'b0;
    @(posedge clk); #1;
    // Abort a native access while BUSY.
    adr = 32'h8000_0000; cyc = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_cyc !== 6'b010000) begin errors++; $display("FAIL abort_busy_scyc: got %b expected 010000", s_cyc); end
    cyc = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_cyc !== 6'b0) begin errors++; $display("FAIL abort_scyc: got %b expected 000000", s_cyc); end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL abort_ack: got %0d acks expected 0", stray); end
    checks++; if (rdt !== 32'h3333_3333) begin errors++; $display("FAIL abort_rdt: got %h expected 33333333", rdt); end
    $display("txn abort adr=%h rdt=%h", adr, rdt);
    // Reset in BUSY with cyc still held.
    cyc = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_busy_ack: got %0b expected 0", ack); end
    checks++; if (s_cyc !== 6'b0) begin errors++; $display("FAIL rst_busy_scyc: got %b expected 000000", s_cyc); end
    checks++; if (rdt !== 32'h0) begin errors++; $display("FAIL rst_busy_rdt: got %h expected 0", rdt); end
    checks++; if (err !== 1'b0 || err_adr !== 32'h0) begin errors++; $display("FAIL rst_busy_err: got %0b/%h expected 0/0", err, err_adr); end
    $display("txn reset-in-busy adr=%h", adr);
    rst = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; bit got; exp_t e;
    logic [31:0] adrs [3];
    adrs[0] = 32'h0000_0000; adrs[1] = 32'h2000_0000; adrs[2] = 32'h0000_0004;
    sb.push_back('{32'h0000_5A5A, 1'b0, 2});
    sb.push_back('{32'h0000_0001, 1'b0, 3});
    sb.push_back('{32'h0000_5A5A, 1'b0, 3});
    adr = adrs[0]; cyc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(lat, got);
      e = sb.pop_front();
      checks++; if (!got || lat !== e.lat) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d (ack=%0b) expected %0d", i, lat, got, e.lat); end
      checks++; if (rdt !== e.rdt) begin errors++; $display("FAIL b2b_rdt[%0d]: got %h expected %h", i, rdt, e.rdt); end
      $display("txn b2b read adr=%h rdt=%h lat=%0d", adr, rdt, lat);
      if (i < 2) adr = adrs[i+1];
    end
    cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; adr = 32'h0; dat = 32'h0; sel = 4'hF; we = 1'b0;
    cyc = 1'b0; err_clr = 1'b0; s5_force = 1'b0;
    test_reset();
    test_auto_ack();
    test_native_wait();
    test_timeout();
    test_unmapped();
    test_abort_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
